// File: rtl/stopwatch_pattern_gen.sv
// MM:SS stopwatch with lap freeze, rendered as four 8x8 glyphs for the LCD driver.
// Optional blinking colon between minutes and seconds: define COLON_BLINK_EN.
module stopwatch_pattern_gen #(
    parameter int TICK_DIV = 100,
    parameter int MAX_MIN  = 59
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         startStop,
    input  logic         Pause,
    output logic [0:255] pattern,
    output logic         running,
    output logic         sec_tick
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MU = 4'(MAX_MIN % 10);
`ifdef COLON_BLINK_EN
    localparam logic COLON_RST = 1'b1;
`else
    localparam logic COLON_RST = 1'b0;
`endif

    typedef enum logic [1:0] {STOP, RUN, LAP} state_t;

    state_t        state, state_nxt;
    logic          ss_q, pause_q, ss_edge, pause_edge;
    logic          tick, snap_load, colon;
    logic [PW-1:0] presc;
    logic [3:0]    sec_u, sec_t, min_u, min_t;
    logic [15:0]   snap, disp;

    // Glyph bitmaps, row 0 in the top byte, column 0 in the MSB of each row.
    function automatic logic [0:63] font(input logic [3:0] d);
        case (d)
            4'd0:    font = 64'h3C666E7666663C00;
            4'd1:    font = 64'h1838181818187E00;
            4'd2:    font = 64'h3C66060C30607E00;
            4'd3:    font = 64'h3C66061C06663C00;
            4'd4:    font = 64'h0C1C3C6C7E0C0C00;
            4'd5:    font = 64'h7E607C0606663C00;
            4'd6:    font = 64'h3C607C6666663C00;
            4'd7:    font = 64'h7E060C1830303000;
            4'd8:    font = 64'h3C66663C66663C00;
            4'd9:    font = 64'h3C66663E060C3800;
            default: font = '0;
        endcase
    endfunction

    function automatic logic [0:255] render(input logic [15:0] v, input logic col);
        logic [0:255] p;
        p = {font(v[15:12]), font(v[11:8]), font(v[7:4]), font(v[3:0])};
        p[64 + 8*2 + 7] = col;
        p[64 + 8*5 + 7] = col;
        return p;
    endfunction

    // Registered copies reset high so a level held through reset is not a command.
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_q    <= 1'b1;
            pause_q <= 1'b1;
        end else begin
            ss_q    <= startStop;
            pause_q <= Pause;
        end
    end

    assign ss_edge    = startStop & ~ss_q;
    assign pause_edge = Pause & ~pause_q;
    assign running    = (state != STOP);
    assign tick       = running && (presc == PW'(TICK_DIV - 1));
    assign sec_tick   = tick;

    always_ff @(posedge clk) begin
        if (reset) state <= STOP;
        else       state <= state_nxt;
    end

    // startStop has priority, so a coincident Pause edge is dropped.
    always_comb begin
        state_nxt = state;
        snap_load = 1'b0;
        case (state)
            STOP: if (ss_edge) state_nxt = RUN;
            RUN: begin
                if (ss_edge) state_nxt = STOP;
                else if (pause_edge) begin
                    state_nxt = LAP;
                    snap_load = 1'b1;
                end
            end
            LAP: begin
                if (ss_edge)         state_nxt = STOP;
                else if (pause_edge) state_nxt = RUN;
            end
            default: state_nxt = STOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)        presc <= '0;
        else if (running) presc <= tick ? '0 : presc + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_u <= '0;
            sec_t <= '0;
            min_u <= '0;
            min_t <= '0;
        end else if (tick) begin
            if (sec_u != 4'd9) sec_u <= sec_u + 4'd1;
            else begin
                sec_u <= '0;
                if (sec_t != 4'd5) sec_t <= sec_t + 4'd1;
                else begin
                    sec_t <= '0;
                    if (min_t == MAX_MT && min_u == MAX_MU) begin
                        min_t <= '0;
                        min_u <= '0;
                    end else if (min_u != 4'd9) min_u <= min_u + 4'd1;
                    else begin
                        min_u <= '0;
                        min_t <= min_t + 4'd1;
                    end
                end
            end
        end
    end

    // Snapshot sees the pre-increment count when a tick lands on the lap edge.
    always_ff @(posedge clk) begin
        if (reset)          snap <= '0;
        else if (snap_load) snap <= {min_t, min_u, sec_t, sec_u};
    end

    assign disp = (state == LAP) ? snap : {min_t, min_u, sec_t, sec_u};

`ifdef COLON_BLINK_EN
    assign colon = (state == RUN) ? (presc < PW'(TICK_DIV / 2)) : 1'b1;
`else
    assign colon = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) pattern <= render(16'h0000, COLON_RST);
        else       pattern <= render(disp, colon);
    end
endmodule

// File: tb/tb_stopwatch_pattern_gen.sv
// Bench for stopwatch_pattern_gen (TICK_DIV=4, MAX_MIN=59): per-cycle scoreboard
// against a seconds-based model, a vector table and hand sequences for corner cases.
module tb_stopwatch_pattern_gen;
    localparam int TD = 4;
`ifdef COLON_BLINK_EN
    localparam logic COL_RST = 1'b1;
`else
    localparam logic COL_RST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, startStop, Pause;
    logic [0:255] pattern;
    logic         running, sec_tick;

    always #5 clk = ~clk;

    stopwatch_pattern_gen #(.TICK_DIV(TD), .MAX_MIN(59)) dut (
        .clk(clk), .reset(reset), .startStop(startStop), .Pause(Pause),
        .pattern(pattern), .running(running), .sec_tick(sec_tick)
    );

    typedef struct {
        logic         running;
        logic         sec_tick;
        logic [0:255] pattern;
    } exp_t;

    typedef struct {
        logic ss;
        logic pa;
        int   n;
        logic run;
        int   disp;
    } vec_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // model: state 0=STOP 1=RUN 2=LAP, counts held as plain seconds
    int   m_state, m_presc, m_secs, m_snap;
    logic m_ssq, m_paq;

    logic [7:0] font_rows [0:9][0:6] = '{
        '{8'h3C,8'h66,8'h6E,8'h76,8'h66,8'h66,8'h3C},
        '{8'h18,8'h38,8'h18,8'h18,8'h18,8'h18,8'h7E},
        '{8'h3C,8'h66,8'h06,8'h0C,8'h30,8'h60,8'h7E},
        '{8'h3C,8'h66,8'h06,8'h1C,8'h06,8'h66,8'h3C},
        '{8'h0C,8'h1C,8'h3C,8'h6C,8'h7E,8'h0C,8'h0C},
        '{8'h7E,8'h60,8'h7C,8'h06,8'h06,8'h66,8'h3C},
        '{8'h3C,8'h60,8'h7C,8'h66,8'h66,8'h66,8'h3C},
        '{8'h7E,8'h06,8'h0C,8'h18,8'h30,8'h30,8'h30},
        '{8'h3C,8'h66,8'h66,8'h3C,8'h66,8'h66,8'h3C},
        '{8'h3C,8'h66,8'h66,8'h3E,8'h06,8'h0C,8'h38}
    };

    function automatic logic [0:255] exp_pat(input int secs, input logic col);
        logic [0:255] p;
        logic [7:0]   row;
        int           d [4];
        p    = '0;
        d[0] = secs / 600;
        d[1] = (secs / 60) % 10;
        d[2] = (secs % 60) / 10;
        d[3] = secs % 10;
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < 7; r++) begin
                row = font_rows[d[k]][r];
                for (int c = 0; c < 8; c++) p[64*k + 8*r + c] = row[7-c];
            end
        p[64 + 16 + 7] = col;
        p[64 + 40 + 7] = col;
        return p;
    endfunction

    function automatic logic [0:255] nocol(input logic [0:255] p);
        logic [0:255] q;
        q      = p;
        q[87]  = 1'b0;
        q[111] = 1'b0;
        return q;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkp(input string nm, input logic [0:255] act, input logic [0:255] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: queue empty at %0t", $time);
        end else begin
            e = sbq.pop_front();
            chk1("sb_running", running, e.running);
            chk1("sb_sec_tick", sec_tick, e.sec_tick);
            chkp("sb_pattern", pattern, e.pattern);
        end
    endtask

    task automatic do_reset(input logic ss, input logic pa);
        exp_t e;
        reset = 1'b1; startStop = ss; Pause = pa;
        m_state = 0; m_presc = 0; m_secs = 0; m_snap = 0;
        m_ssq = 1'b1; m_paq = 1'b1;
        e.running = 1'b0; e.sec_tick = 1'b0; e.pattern = exp_pat(0, COL_RST);
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_head();
    endtask

    task automatic step(input logic ss, input logic pa);
        exp_t e;
        logic ss_e, pa_e, tk, col;
        int   ns;
        ss_e = ss && !m_ssq;
        pa_e = pa && !m_paq;
        tk   = (m_state != 0) && (m_presc == TD - 1);
`ifdef COLON_BLINK_EN
        col = (m_state == 1) ? (m_presc < TD / 2) : 1'b1;
`else
        col = 1'b0;
`endif
        e.pattern = exp_pat((m_state == 2) ? m_snap : m_secs, col);
        ns = m_state;
        if (ss_e) ns = (m_state == 0) ? 1 : 0;
        else if (pa_e) begin
            if (m_state == 1) begin
                ns = 2;
                m_snap = m_secs;
            end else if (m_state == 2) ns = 1;
        end
        if (tk) m_secs = (m_secs + 1) % 3600;
        if (m_state != 0) m_presc = (m_presc + 1) % TD;
        m_state = ns; m_ssq = ss; m_paq = pa;
        e.running  = (m_state != 0);
        e.sec_tick = (m_state != 0) && (m_presc == TD - 1);
        sbq.push_back(e);
        startStop = ss; Pause = pa;
        @(posedge clk);
        @(negedge clk);
        compare_head();
    endtask

    task automatic run_until_secs(input int target, input int budget);
        int i;
        i = 0;
        while (m_secs != target && i < budget) begin
            step(1'b1, 1'b0);
            i++;
        end
        total++;
        if (m_secs != target) begin
            bad++;
            $display("FAIL timeout: secs %0d want %0d", m_secs, target);
        end
    endtask

    vec_t tbl [6];
    int   sv, nticks;

    initial begin
        reset = 1'b1; startStop = 1'b0; Pause = 1'b0;
        tbl[0] = '{ss: 1'b0, pa: 1'b0, n: 20, run: 1'b0, disp: 0};
        tbl[1] = '{ss: 1'b1, pa: 1'b0, n: 1,  run: 1'b1, disp: 0};
        tbl[2] = '{ss: 1'b1, pa: 1'b0, n: 41, run: 1'b1, disp: 10};
        tbl[3] = '{ss: 1'b1, pa: 1'b0, n: 40, run: 1'b1, disp: 20};
        tbl[4] = '{ss: 1'b0, pa: 1'b0, n: 4,  run: 1'b1, disp: 21};
        tbl[5] = '{ss: 1'b1, pa: 1'b0, n: 1,  run: 1'b0, disp: 21};

        // reset state, start, held level, stop
        do_reset(1'b0, 1'b0);
        chk1("rst_running", running, 1'b0);
        chkp("rst_pattern", nocol(pattern), exp_pat(0, 1'b0));
        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < tbl[v].n; j++) step(tbl[v].ss, tbl[v].pa);
            chk1($sformatf("tbl%0d_running", v), running, tbl[v].run);
            chkp($sformatf("tbl%0d_pattern", v), nocol(pattern), exp_pat(tbl[v].disp, 1'b0));
        end

        // lap freeze at 00:05, release after 8 cycles
        do_reset(1'b0, 1'b0);
        step(1'b0, 1'b0);
        run_until_secs(5, 100);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        nticks = 0;
        for (int j = 0; j < 8; j++) begin
            step(1'b1, 1'b0);
            if (sec_tick) nticks++;
            chkp("lap_frozen", nocol(pattern), exp_pat(5, 1'b0));
        end
        total++;
        if (nticks != 2) begin
            bad++;
            $display("FAIL lap_ticks: got %0d want 2", nticks);
        end
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chkp("lap_release", nocol(pattern), exp_pat(7, 1'b0));

        // 59:59 wraps to 00:00
        do_reset(1'b0, 1'b0);
        step(1'b0, 1'b0);
        run_until_secs(3599, 15000);
        step(1'b1, 1'b0);
        chkp("show_5959", nocol(pattern), exp_pat(3599, 1'b0));
        run_until_secs(0, 8);
        step(1'b1, 1'b0);
        chkp("wrap_0000", nocol(pattern), exp_pat(0, 1'b0));
        chk1("wrap_running", running, 1'b1);

        // simultaneous edges in RUN, Pause in STOP, tick on RUN->STOP
        do_reset(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int j = 0; j < 7; j++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk1("both_edges_stop", running, 1'b0);
        sv = m_secs;
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk1("pause_in_stop", running, 1'b0);
        step(1'b0, 1'b0);
        chkp("stop_display", nocol(pattern), exp_pat(sv, 1'b0));
        step(1'b1, 1'b0);
        chk1("restart", running, 1'b1);
        for (int j = 0; j < 2 * TD && m_presc != TD - 1; j++) step(1'b0, 1'b0);
        sv = m_secs;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk1("tick_stop_running", running, 1'b0);
        chkp("tick_stop_count", nocol(pattern), exp_pat(sv + 1, 1'b0));

        // reset mid-run at 03:21 with both inputs held high
        do_reset(1'b0, 1'b0);
        step(1'b0, 1'b0);
        run_until_secs(201, 1000);
        step(1'b1, 1'b0);
        do_reset(1'b1, 1'b1);
        chk1("midrst_running", running, 1'b0);
        chk1("midrst_tick", sec_tick, 1'b0);
        chkp("midrst_pattern", nocol(pattern), exp_pat(0, 1'b0));
        for (int j = 0; j < 3; j++) step(1'b1, 1'b1);
        chk1("held_no_cmd", running, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk1("post_rst_start", running, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
